// File: rtl/lfsr_pkg.sv
// LFSR shared constants: topology encoding and
// default maximal-length tap masks for widths 3..32.
package lfsr_pkg;

    localparam int TOPO_FIB    = 0;
    localparam int TOPO_GALOIS = 1;

    // Primitive polynomial minus the x^W term.
    // Bit k set means an x^k term; bit 0 is the constant.
    function automatic logic [31:0] lfsr_poly(input int w);
        logic [31:0] p;
        p = 32'h0;
        unique case (w)
            3:  p = 32'h0000_0005;
            4:  p = 32'h0000_0009;
            5:  p = 32'h0000_0009;
            6:  p = 32'h0000_0021;
            7:  p = 32'h0000_0041;
            8:  p = 32'h0000_0071;
            9:  p = 32'h0000_0021;
            10: p = 32'h0000_0081;
            11: p = 32'h0000_0201;
            12: p = 32'h0000_0053;
            13: p = 32'h0000_001B;
            14: p = 32'h0000_002B;
            15: p = 32'h0000_4001;
            16: p = 32'h0000_A011;
            17: p = 32'h0000_4001;
            18: p = 32'h0000_0801;
            19: p = 32'h0000_0047;
            20: p = 32'h0002_0001;
            21: p = 32'h0008_0001;
            22: p = 32'h0020_0001;
            23: p = 32'h0004_0001;
            24: p = 32'h00C2_0001;
            25: p = 32'h0040_0001;
            26: p = 32'h0000_0047;
            27: p = 32'h0000_0027;
            28: p = 32'h0200_0001;
            29: p = 32'h0800_0001;
            30: p = 32'h0000_0053;
            31: p = 32'h1000_0001;
            32: p = 32'h0040_0007;
            default: p = 32'h0;
        endcase
        return p;
    endfunction

    // Galois inject mask is the polynomial itself.
    function automatic logic [31:0] galois_taps(input int w);
        return lfsr_poly(w);
    endfunction

    // Fibonacci select mask: x^k term maps to q[k-1],
    // and the x^W term always selects q[W-1].
    function automatic logic [31:0] fib_taps(input int w);
        logic [31:0] p;
        p = lfsr_poly(w) & ~32'h1;
        return (p >> 1) | (32'h1 << (w - 1));
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One LFSR step, purely combinational.
// Topology and taps are fixed at elaboration.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int           W      = 5,
    parameter logic [W-1:0] TAPS   = 5'b10100,
    parameter int           GALOIS = TOPO_FIB
) (
    input  logic [W-1:0] i_q,
    output logic [W-1:0] o_q_n
);

    generate
        if (GALOIS == TOPO_GALOIS) begin : g_galois
            logic [W-1:0] w_inj;
            assign w_inj = {W{i_q[W-1]}} & TAPS;
            assign o_q_n = {i_q[W-2:0], 1'b0} ^ w_inj;
        end else begin : g_fib
            logic w_fb;
            assign w_fb  = ^(i_q & TAPS);
            assign o_q_n = {i_q[W-2:0], w_fb};
        end
    endgenerate

endmodule

// File: rtl/lfsr_param.sv
// Parametrised LFSR with seed load, zero-seed guard
// and period measurement against the start state.
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int           W      = 5,
    parameter logic [W-1:0] TAPS   = 5'b10100,
    parameter int           GALOIS = TOPO_FIB,
    parameter logic [W-1:0] SEED   = 5'b11111
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] q,
    output logic         bit_out,
    output logic         wrap,
    output logic [W-1:0] period,
    output logic         seed_err
);

    logic [W-1:0] r_q;
    logic [W-1:0] r_start;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_period;
    logic         r_wrap;
    logic         r_seed_err;
    logic [W-1:0] w_q_n;
    logic         w_hit;
    logic         w_sat;

    lfsr_step #(
        .W      (W),
        .TAPS   (TAPS),
        .GALOIS (GALOIS)
    ) u_step (
        .i_q   (r_q),
        .o_q_n (w_q_n)
    );

    assign w_hit = (w_q_n == r_start);
    assign w_sat = (r_cnt == {W{1'b1}});

    // State, start marker, step counter and pulses.
    // A zero seed would lock up, so SEED is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= SEED;
            r_start    <= SEED;
            r_cnt      <= '0;
            r_period   <= '0;
            r_wrap     <= 1'b0;
            r_seed_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_seed_err <= 1'b0;
            if (load) begin
                r_cnt <= '0;
                if (seed != '0) begin
                    r_q     <= seed;
                    r_start <= seed;
                end else begin
                    r_q        <= SEED;
                    r_start    <= SEED;
                    r_seed_err <= 1'b1;
                end
            end else if (en) begin
                r_q <= w_q_n;
                if (w_hit) begin
                    r_wrap   <= 1'b1;
                    r_period <= r_cnt + W'(1);
                    r_cnt    <= '0;
                end else if (!w_sat) begin
                    r_cnt <= r_cnt + W'(1);
                end
            end
        end
    end

    assign q        = r_q;
    assign bit_out  = r_q[W-1];
    assign wrap     = r_wrap;
    assign period   = r_period;
    assign seed_err = r_seed_err;

endmodule

// File: tb/tb_lfsr_param.sv
// Scoreboard bench for lfsr_param: a Fibonacci and a
// Galois instance share stimulus and a reference model.
module tb_lfsr_param;

    typedef struct {
        logic [4:0] q;
        logic [4:0] start;
        int         cnt;
        logic       wrap;
        logic [4:0] period;
        logic       serr;
    } mdl_t;

    typedef struct {
        logic [4:0] q;
        logic       wrap;
        logic [4:0] period;
        logic       serr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [4:0] seed;
    logic [4:0] f_q, f_per, g_q, g_per;
    logic       f_bit, f_wrap, f_serr;
    logic       g_bit, g_wrap, g_serr;

    int   n_vec = 0;
    int   n_bad = 0;
    mdl_t mf, mg;
    exp_t qf[$];
    exp_t qg[$];

    always #5 clk = ~clk;

    lfsr_param u_fib (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .seed(seed), .q(f_q), .bit_out(f_bit),
        .wrap(f_wrap), .period(f_per),
        .seed_err(f_serr)
    );

    lfsr_param #(
        .W(5), .TAPS(5'b01001),
        .GALOIS(1), .SEED(5'b11111)
    ) u_gal (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .seed(seed), .q(g_q), .bit_out(g_bit),
        .wrap(g_wrap), .period(g_per),
        .seed_err(g_serr)
    );

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endfunction

    // Next state from the polynomial, in integer arithmetic.
    function automatic logic [4:0] nxt(input logic [4:0] q,
                                       input bit g);
        int v;
        v = int'(q);
        if (g)
            v = ((v * 2) % 32) ^ ((v >= 16) ? 9 : 0);
        else
            v = (v * 2) % 32 + ($countones(q & 5'b10100) % 2);
        return 5'(v);
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input bit g,
                                   input bit r, input bit l,
                                   input bit e,
                                   input logic [4:0] s);
        mdl_t n;
        logic [4:0] x;
        n = m;
        n.wrap = 1'b0;
        n.serr = 1'b0;
        if (r) begin
            n.q = 5'd31; n.start = 5'd31;
            n.cnt = 0;   n.period = 5'd0;
        end else if (l) begin
            n.cnt = 0;
            if (s == 5'd0) begin
                n.q = 5'd31; n.start = 5'd31; n.serr = 1'b1;
            end else begin
                n.q = s; n.start = s;
            end
        end else if (e) begin
            x = nxt(m.q, g);
            n.q = x;
            if (x == m.start) begin
                n.wrap = 1'b1;
                n.period = 5'(m.cnt + 1);
                n.cnt = 0;
            end else if (m.cnt < 31) begin
                n.cnt = m.cnt + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(input mdl_t m);
        exp_t x;
        x.q = m.q; x.wrap = m.wrap;
        x.period = m.period; x.serr = m.serr;
        return x;
    endfunction

    // Drive at negedge, push expectation, return at next negedge.
    task automatic step(input bit r, input bit l, input bit e,
                        input logic [4:0] s);
        rst = r; load = l; en = e; seed = s;
        mf = mstep(mf, 1'b0, r, l, e, s);
        mg = mstep(mg, 1'b1, r, l, e, s);
        qf.push_back(to_exp(mf));
        qg.push_back(to_exp(mg));
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per edge and compares.
    initial begin
        exp_t ef, eg;
        forever begin
            @(posedge clk);
            #1;
            if (qf.size() != 0 && qg.size() != 0) begin
                ef = qf.pop_front();
                eg = qg.pop_front();
                chk("f.q", 32'(f_q), 32'(ef.q));
                chk("f.bit", 32'(f_bit), 32'(ef.q[4]));
                chk("f.wrap", 32'(f_wrap), 32'(ef.wrap));
                chk("f.period", 32'(f_per), 32'(ef.period));
                chk("f.serr", 32'(f_serr), 32'(ef.serr));
                chk("g.q", 32'(g_q), 32'(eg.q));
                chk("g.bit", 32'(g_bit), 32'(eg.q[4]));
                chk("g.wrap", 32'(g_wrap), 32'(eg.wrap));
                chk("g.period", 32'(g_per), 32'(eg.period));
                chk("g.serr", 32'(g_serr), 32'(eg.serr));
            end
        end
    end

    initial begin
        logic [4:0] seq [4];
        bit         seen [32];
        int         nd, wraps, wat;
        seq[0] = 5'b11110; seq[1] = 5'b11100;
        seq[2] = 5'b11000; seq[3] = 5'b10001;
        mf = '{5'd31, 5'd31, 0, 1'b0, 5'd0, 1'b0};
        mg = mf;
        rst = 1'b1; en = 1'b0; load = 1'b0; seed = '0;
        @(negedge clk);

        step(1, 0, 0, 5'd0);
        step(1, 0, 0, 5'd0);
        chk("rst.q", 32'(f_q), 32'h1F);
        chk("rst.wrap", 32'(f_wrap), 32'h0);
        chk("rst.period", 32'(f_per), 32'h0);
        chk("rst.serr", 32'(f_serr), 32'h0);

        foreach (seen[i]) seen[i] = 1'b0;
        nd = 0; wraps = 0; wat = 0;
        for (int i = 1; i <= 31; i++) begin
            step(0, 0, 1, 5'd0);
            if (i <= 4) chk("seq.q", 32'(f_q), 32'(seq[i-1]));
            if (i == 1) chk("gal.first", 32'(g_q), 32'h17);
            if (f_wrap) begin wraps++; wat = i; end
            if (!seen[f_q]) begin seen[f_q] = 1'b1; nd++; end
        end
        chk("wrap.count", 32'(wraps), 32'd1);
        chk("wrap.step", 32'(wat), 32'd31);
        chk("full.q", 32'(f_q), 32'h1F);
        chk("full.period", 32'(f_per), 32'd31);
        chk("distinct", 32'(nd), 32'd31);
        chk("zero.seen", 32'(seen[0]), 32'd0);
        chk("gal.period", 32'(g_per), 32'd31);
        chk("gal.wrap", 32'(g_wrap), 32'd1);

        step(0, 0, 1, 5'd0);
        step(0, 1, 0, 5'd0);
        chk("zs.q", 32'(f_q), 32'h1F);
        chk("zs.serr", 32'(f_serr), 32'h1);
        step(0, 0, 0, 5'd0);
        chk("zs.clear", 32'(f_serr), 32'h0);
        step(0, 1, 0, 5'd1);
        chk("ld.q", 32'(f_q), 32'h01);
        wraps = 0; wat = 0;
        for (int i = 1; i <= 31; i++) begin
            step(0, 0, 1, 5'd0);
            if (f_wrap) begin wraps++; wat = i; end
        end
        chk("ld.wraps", 32'(wraps), 32'd1);
        chk("ld.wstep", 32'(wat), 32'd31);
        chk("ld.q31", 32'(f_q), 32'h01);

        wraps = 0; wat = 0;
        for (int i = 1; i <= 62; i++) begin
            step(0, 0, (i % 2) == 1, 5'd0);
            if (f_wrap) begin wraps++; wat = i; end
        end
        chk("tg.wraps", 32'(wraps), 32'd1);
        chk("tg.wstep", 32'(wat), 32'd61);
        chk("tg.q", 32'(f_q), 32'h01);
        step(0, 1, 1, 5'b00110);
        chk("ldwin.q", 32'(f_q), 32'h06);

        for (int i = 0; i < 5; i++) step(0, 0, 1, 5'd0);
        step(1, 1, 1, 5'd0);
        chk("rl.q", 32'(f_q), 32'h1F);
        chk("rl.period", 32'(f_per), 32'h0);
        chk("rl.serr", 32'(f_serr), 32'h0);
        step(0, 0, 1, 5'd0);
        chk("rl.restart", 32'(f_q), 32'h1E);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] s;
            s = ($urandom_range(0, 3) == 0) ?
                5'd0 : 5'($urandom);
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, s);
        end
        chk("sb.drain", 32'(qf.size() + qg.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
